// File: rtl/ece571f23_g5_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : ece571f23_g5_aes_pkg
// Brief  : Shared AES definitions for the forward and inverse ciphers:
//          FSM state enum, round constants, GF(2^8) helpers, S-box and
//          inverse S-box, and one AES-128 key-schedule step.
// Rev    : 1.0  initial release
// ============================================================================
package ece571f23_g5_aes_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_KEYEXP = 3'd1,
      S_ADDKEY = 3'd2,
      S_ROUND  = 3'd3,
      S_DONE   = 3'd4
   } aes_state_e;

   localparam logic [7:0] c_rcon [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] acc;
      p   = a;
      acc = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   // Undo the affine transform first, then invert in the field.
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   // Produce round key i from round key i-1 (word 0 is bits [127:96]).
   function automatic logic [127:0] key_expand_step(input logic [127:0] rk,
                                                     input logic [7:0]   rc);
      logic [31:0] t;
      logic [31:0] n0, n1, n2, n3;
      t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
           ^ {rc, 24'h000000};
      n0 = rk[127:96] ^ t;
      n1 = rk[95:64]  ^ n0;
      n2 = rk[63:32]  ^ n1;
      n3 = rk[31:0]   ^ n2;
      return {n0, n1, n2, n3};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ece571f23_g5_aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module : ece571f23_g5_aes_inv_round
// Brief  : One combinational AES inverse round:
//          InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
//          (InvMixColumns skipped when last is high).
// Ports  : state      - current 128-bit state, byte 0 at [127:120]
//          rk         - round key for this round
//          last       - final round, no InvMixColumns
//          next_state - resulting state
// Rev    : 1.0  initial release
// ============================================================================
module ece571f23_g5_aes_inv_round
   import ece571f23_g5_aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] next_state
);

   logic [127:0] w_ark;
   logic [127:0] w_mix;

   // Byte i sits at row i%4, column i/4. InvShiftRows moves row r right by
   // r, so output column c takes input column (c - r) mod 4.
   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int c_row = i % 4;
      localparam int c_col = i / 4;
      localparam int c_src = c_row + 4 * ((c_col - c_row + 4) % 4);
      assign w_ark[127-8*i -: 8] = inv_sbox(state[127-8*c_src -: 8])
                                   ^ rk[127-8*i -: 8];
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = w_ark[127-32*c -: 8];
      assign a1 = w_ark[119-32*c -: 8];
      assign a2 = w_ark[111-32*c -: 8];
      assign a3 = w_ark[103-32*c -: 8];
      assign w_mix[127-32*c -: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1)
                                  ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
      assign w_mix[119-32*c -: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1)
                                  ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
      assign w_mix[111-32*c -: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1)
                                  ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
      assign w_mix[103-32*c -: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1)
                                  ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
   end

   assign next_state = last ? w_ark : w_mix;

endmodule
`default_nettype wire

// File: rtl/ece571f23_g5_aes_inv_cipher_seq.sv
`default_nettype none
// ============================================================================
// Module : ece571f23_g5_aes_inv_cipher_seq
// Brief  : Iterative AES-128 decryptor, one round per clock. Expands the key
//          schedule into a register array, then runs the inverse cipher.
// Ports  : clk, rst_n (async, active-low)
//          in_valid/in_ready, ciphertext, key   - job input handshake
//          out_valid/out_ready, plaintext       - result handshake
//          busy                                 - key expansion or rounds
// Rev    : 1.0  initial release
// ============================================================================
module ece571f23_g5_aes_inv_cipher_seq
   import ece571f23_g5_aes_pkg::*;
#(
   parameter int NR = 10   // only 10 (AES-128) is supported
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         busy
);

   aes_state_e   r_fsm;
   aes_state_e   w_fsm_next;
   logic [127:0] r_state_q;
   logic [127:0] r_rk [0:NR];
   logic [3:0]   r_cnt;
   logic [127:0] r_plaintext;

   logic [3:0]   w_prev_idx;
   logic [7:0]   w_rcon;
   logic [127:0] w_expand;
   logic [127:0] w_round_key;
   logic [127:0] w_round_out;

   // Guard the table/array reads so idle counter values never index out of range.
   assign w_prev_idx  = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
   assign w_rcon      = (r_cnt >= 4'd1 && r_cnt <= 4'd10) ? c_rcon[r_cnt] : 8'h00;
   assign w_expand    = key_expand_step(r_rk[w_prev_idx], w_rcon);
   assign w_round_key = (r_cnt <= 4'(NR)) ? r_rk[r_cnt] : '0;

   ece571f23_g5_aes_inv_round u_round (
      .state      (r_state_q),
      .rk         (w_round_key),
      .last       (r_cnt == 4'd0),
      .next_state (w_round_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fsm <= S_IDLE;
      else        r_fsm <= w_fsm_next;
   end

   always_comb begin
      w_fsm_next = r_fsm;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_fsm_next = S_KEYEXP;
         end
         S_KEYEXP: begin
            busy = 1'b1;
            if (r_cnt == 4'(NR)) w_fsm_next = S_ADDKEY;
         end
         S_ADDKEY: begin
            busy       = 1'b1;
            w_fsm_next = S_ROUND;
         end
         S_ROUND: begin
            busy = 1'b1;
            if (r_cnt == 4'd0) w_fsm_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_fsm_next = S_IDLE;
         end
         default: w_fsm_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q   <= '0;
         r_cnt       <= '0;
         r_plaintext <= '0;
         for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               if (in_valid) begin
                  r_state_q <= ciphertext;
                  r_rk[0]   <= key;
                  r_cnt     <= 4'd1;
               end
            end
            S_KEYEXP: begin
               r_rk[r_cnt] <= w_expand;
               r_cnt       <= r_cnt + 4'd1;
            end
            S_ADDKEY: begin
               r_state_q <= r_state_q ^ r_rk[NR];
               r_cnt     <= 4'(NR - 1);
            end
            S_ROUND: begin
               r_state_q <= w_round_out;
               if (r_cnt == 4'd0) r_plaintext <= w_round_out;
               else               r_cnt       <= r_cnt - 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign plaintext = r_plaintext;

endmodule
`default_nettype wire
